// File: rtl/wca_strobe_pkg.sv
// Shared types for the WCA strobe-rate generator: FSM state encoding and mode constants.
package wca_strobe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } strobe_state_e;

   localparam logic STROBE_PERIODIC = 1'b0;
   localparam logic STROBE_ONESHOT  = 1'b1;

endpackage

// File: rtl/wca_strobe_counter.sv
// Phase counter for the strobe generator: counts qualified strobes up to a limit
// and flags the terminal strobe combinationally.
module wca_strobe_counter #(
   parameter int WIDTH = 24
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // The count never passes limit, so limit = all-ones cannot overflow.
   assign terminal = inc && (count == limit);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear || terminal) begin
         count <= '0;
      end else if (inc) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/wca_dsp_strobe_gen.sv
// Strobe-rate generator: one output strobe every rate+1 qualified input strobes,
// periodic or one-shot. Define WCA_STROBE_TICKS_EN to add the emitted-strobe counter.
module wca_dsp_strobe_gen
   import wca_strobe_pkg::*;
#(
   parameter int WIDTH      = 24,
   parameter int TICK_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  oneshot,
   input  logic                  sync_clear,
   input  logic                  strobe_in,
   input  logic [WIDTH-1:0]      rate,
   output logic                  strobe_out,
   output logic [WIDTH-1:0]      count,
   output logic                  active,
   output logic                  done,
`ifdef WCA_STROBE_TICKS_EN
   output logic [TICK_WIDTH-1:0] ticks,
`endif
   output strobe_state_e         state_dbg
);

   strobe_state_e    state;
   logic [WIDTH-1:0] rate_act;
   logic             mode_q;
   logic             run_ok;
   logic             cnt_clear;
   logic             cnt_terminal;
   logic             term_hit;

   if (WIDTH < 1 || TICK_WIDTH < 1) begin : g_param_check
      $error("wca_dsp_strobe_gen: WIDTH and TICK_WIDTH must be at least 1");
   end

   assign run_ok    = enable && (state == ST_RUN);
   assign cnt_clear = !run_ok || sync_clear;
   // sync_clear outranks the terminal strobe, so a colliding terminal is swallowed.
   assign term_hit  = run_ok && !sync_clear && cnt_terminal;
   assign state_dbg = state;

   wca_strobe_counter #(.WIDTH(WIDTH)) u_counter (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (cnt_clear),
      .inc      (strobe_in),
      .limit    (rate_act),
      .count    (count),
      .terminal (cnt_terminal)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         rate_act   <= '0;
         mode_q     <= STROBE_PERIODIC;
         strobe_out <= 1'b0;
         active     <= 1'b0;
         done       <= 1'b0;
      end else begin
         strobe_out <= 1'b0;
         if (!enable) begin
            state  <= ST_IDLE;
            active <= 1'b0;
            done   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state    <= ST_RUN;
                  active   <= 1'b1;
                  rate_act <= rate;
                  mode_q   <= oneshot;
               end
               ST_RUN: begin
                  if (sync_clear) begin
                     rate_act <= rate;
                  end else if (term_hit) begin
                     strobe_out <= 1'b1;
                     rate_act   <= rate;
                     if (mode_q == STROBE_ONESHOT) begin
                        state  <= ST_DONE;
                        active <= 1'b0;
                        done   <= 1'b1;
                     end
                  end
               end
               ST_DONE: begin
                  done <= 1'b1;
               end
               default: begin
                  state  <= ST_IDLE;
                  active <= 1'b0;
                  done   <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef WCA_STROBE_TICKS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ticks <= '0;
      end else if (enable && state == ST_IDLE) begin
         ticks <= '0;
      end else if (term_hit) begin
         ticks <= ticks + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_wca_dsp_strobe_gen.sv
// Bench for wca_dsp_strobe_gen: a 24-bit and an 8-bit instance share stimulus and
// are checked each cycle against a behavioural model through an expected queue.
module tb_wca_dsp_strobe_gen;
   import wca_strobe_pkg::*;

   localparam int EXP_W = 29;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        oneshot = 1'b0;
   logic        sync_clear = 1'b0;
   logic        strobe_in = 1'b0;
   logic [23:0] rate = '0;

   logic          so_a, act_a, done_a, so_b, act_b, done_b;
   logic [23:0]   cnt_a;
   logic [7:0]    cnt_b;
   strobe_state_e st_a, st_b;
`ifdef WCA_STROBE_TICKS_EN
   logic [15:0]   ticks_a, ticks_b;
`endif

   int checks = 0;
   int failures = 0;

   logic [EXP_W-1:0] exp_q[$];
`ifdef WCA_STROBE_TICKS_EN
   logic [15:0]      exp_ticks_q[$];
`endif

   strobe_state_e m_state;
   logic [23:0]   m_count, m_rate;
   logic          m_mode;
   logic [15:0]   m_ticks;
   logic          last_strobe;

   wca_dsp_strobe_gen #(.WIDTH(24), .TICK_WIDTH(16)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .enable(enable), .oneshot(oneshot),
      .sync_clear(sync_clear), .strobe_in(strobe_in), .rate(rate),
      .strobe_out(so_a), .count(cnt_a), .active(act_a), .done(done_a),
`ifdef WCA_STROBE_TICKS_EN
      .ticks(ticks_a),
`endif
      .state_dbg(st_a)
   );

   wca_dsp_strobe_gen #(.WIDTH(8), .TICK_WIDTH(16)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .enable(enable), .oneshot(oneshot),
      .sync_clear(sync_clear), .strobe_in(strobe_in), .rate(rate[7:0]),
      .strobe_out(so_b), .count(cnt_b), .active(act_b), .done(done_b),
`ifdef WCA_STROBE_TICKS_EN
      .ticks(ticks_b),
`endif
      .state_dbg(st_b)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = ST_IDLE;
      m_count = '0;
      m_rate  = '0;
      m_mode  = 1'b0;
      m_ticks = '0;
      exp_q.delete();
`ifdef WCA_STROBE_TICKS_EN
      exp_ticks_q.delete();
`endif
   endtask

   // Next-cycle behaviour from the current inputs; result pushed to the scoreboard.
   task automatic model_step();
      logic exp_so;
      exp_so = 1'b0;
      if (!enable) begin
         m_state = ST_IDLE;
         m_count = '0;
      end else begin
         case (m_state)
            ST_IDLE: begin
               m_state = ST_RUN;
               m_rate  = rate;
               m_mode  = oneshot;
               m_count = '0;
               m_ticks = '0;
            end
            ST_RUN: begin
               if (sync_clear) begin
                  m_count = '0;
                  m_rate  = rate;
               end else if (strobe_in) begin
                  if (m_count == m_rate) begin
                     m_count = '0;
                     m_rate  = rate;
                     exp_so  = 1'b1;
                     m_ticks = m_ticks + 16'd1;
                     if (m_mode) m_state = ST_DONE;
                  end else begin
                     m_count = m_count + 24'd1;
                  end
               end
            end
            default: m_count = '0;
         endcase
      end
      exp_q.push_back({m_state, exp_so, (m_state == ST_RUN), (m_state == ST_DONE), m_count});
`ifdef WCA_STROBE_TICKS_EN
      exp_ticks_q.push_back(m_ticks);
`endif
   endtask

   // driver: one clock with the inputs currently applied, then scoreboard compare
   task automatic tick();
      logic [EXP_W-1:0] exp_v;
      model_step();
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         exp_v = exp_q.pop_front();
         check("out_w24", {st_a, so_a, act_a, done_a, cnt_a}, exp_v);
         check("out_w8", {st_b, so_b, act_b, done_b, 16'd0, cnt_b}, exp_v);
      end
`ifdef WCA_STROBE_TICKS_EN
      if (exp_ticks_q.size() != 0) begin
         logic [15:0] et;
         et = exp_ticks_q.pop_front();
         check("ticks_w24", ticks_a, et);
         check("ticks_w8", ticks_b, et);
      end
`endif
      last_strobe = so_a;
   endtask

   task automatic go_idle();
      enable = 1'b0; sync_clear = 1'b0; strobe_in = 1'b0;
      tick(); tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, {st_a, so_a, act_a, done_a, cnt_a}, '0);
      check({tag, "_b"}, {st_b, so_b, act_b, done_b, cnt_b}, '0);
`ifdef WCA_STROBE_TICKS_EN
      check({tag, "_ticks"}, {ticks_a, ticks_b}, '0);
`endif
   endtask

   initial begin
      int first_idx;
      model_reset();
      last_strobe = 1'b0;

      // reset state
      #12;
      check_all_zero("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;
      tick();

      // periodic, rate 3, continuous strobe: first output on the 5th clock
      rate = 24'd3; strobe_in = 1'b1; oneshot = 1'b0; enable = 1'b1;
      first_idx = -1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (last_strobe && first_idx < 0) first_idx = i;
      end
      check("first_strobe_latency", first_idx, 5);
      go_idle();

      // rate change mid-period: 9 -> 1 at count 4
      rate = 24'd9; strobe_in = 1'b1; enable = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("count_before_change", cnt_a, 4);
      rate = 24'd1;
      for (int i = 0; i < 16; i++) tick();
      go_idle();

      // one-shot, rate 2, strobe every 3rd clock
      oneshot = 1'b1; rate = 24'd2; enable = 1'b1;
      for (int i = 0; i < 24; i++) begin
         strobe_in = (i % 3 == 2);
         tick();
      end
      check("oneshot_done", done_a, 1);
      strobe_in = 1'b0; enable = 1'b0;
      tick();
      check("oneshot_done_clr", done_a, 0);
      oneshot = 1'b0;
      tick();

      // sync_clear colliding with terminal strobe
      rate = 24'd2; enable = 1'b1; strobe_in = 1'b0;
      tick();
      strobe_in = 1'b1; tick(); tick();
      sync_clear = 1'b1; tick();
      sync_clear = 1'b0; tick();
      for (int i = 0; i < 8; i++) tick();
      go_idle();

      // enable dropping on a terminal strobe
      rate = 24'd1; enable = 1'b1; strobe_in = 1'b1;
      tick(); tick();
      enable = 1'b0; tick(); tick();

      // rate 0: output mirrors strobe_in one clock later
      rate = 24'd0; enable = 1'b1; strobe_in = 1'b0;
      tick();
      for (int i = 0; i < 30; i++) begin
         strobe_in = ($urandom_range(0, 1) == 1);
         tick();
      end
      go_idle();

      // max 8-bit rate: period of 256 strobes on both widths
      rate = 24'd255; enable = 1'b1; strobe_in = 1'b1;
      for (int i = 0; i < 530; i++) tick();
      go_idle();

      // random mix
      for (int i = 0; i < 300; i++) begin
         strobe_in  = ($urandom_range(0, 3) != 0);
         sync_clear = ($urandom_range(0, 9) == 0);
         enable     = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 7) == 0) rate = 24'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
         tick();
      end
      sync_clear = 1'b0; oneshot = 1'b0;
      go_idle();

      // ticks: five outputs, then re-enable clears
      rate = 24'd0; enable = 1'b1; strobe_in = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      strobe_in = 1'b0; tick();
      enable = 1'b0; tick();
      enable = 1'b1; tick(); tick();

      // asynchronous reset mid-period
      rate = 24'd7; strobe_in = 1'b1;
      tick(); tick(); tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      enable = 1'b0; strobe_in = 1'b0;
      @(posedge clock); #3;
      reset_n = 1'b1;
      @(posedge clock); #1;
      tick();
      enable = 1'b1; rate = 24'd1; strobe_in = 1'b1;
      for (int i = 0; i < 6; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wca_dsp_strobe_gen.md
# wca_dsp_strobe_gen

Parametrised strobe-rate generator for the WCA DSP chain: counts qualified input strobes and emits a single-cycle output strobe every `rate+1` inputs. Supports periodic and one-shot modes, a glitch-free double-buffered rate, and a synchronous phase clear. It sits between a sample-rate strobe source, such as an ADC or CIC stage strobe, and downstream decimators, interpolators and packetisers that need a derived rate.

## Interface

Parameters:
- `WIDTH`, 24: counter and rate width in bits.
- `TICK_WIDTH`, 16: width of the emitted-strobe counter. Used only with `WCA_STROBE_TICKS_EN`.

Ports:
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: run gate. Low forces IDLE.
- `oneshot` in 1: mode select. 0 = periodic, 1 = one-shot. Sampled on IDLE→RUN.
- `sync_clear` in 1: synchronous phase clear. Resets the count and reloads the rate.
- `strobe_in` in 1: qualifying input strobe. Counts one per clock while high.
- `rate` in WIDTH: divide value. Output period is `rate+1` input strobes.
- `strobe_out` out 1: registered single-cycle output strobe.
- `count` out WIDTH: current phase count.
- `active` out 1: high in RUN.
- `done` out 1: high in DONE (one-shot complete).
- `ticks` out TICK_WIDTH: emitted-strobe count. Present only with `WCA_STROBE_TICKS_EN`.

## Operation

- **Reset values (reset_n low):**
  - state = IDLE
  - `count`, `rate_act`, `strobe_out`, `active`, `done`, `ticks` = 0
  - `mode_q` = 0
- **States:** IDLE, RUN, DONE. Encoding comes from the package.
- **IDLE:**
  - `count` = 0, no strobes.
  - `enable` high → RUN next clock.
  - On that transition: `rate_act` ← `rate`, `mode_q` ← `oneshot`.
- **RUN:**
  - `strobe_in` high and `count` != `rate_act` → `count` ← `count`+1.
  - `strobe_in` high and `count` == `rate_act` (terminal) → `count` ← 0, `strobe_out` ← 1 next clock, `rate_act` ← `rate`.
  - Terminal with `mode_q` = 1 → DONE.
- **DONE:**
  - `count` = 0, `strobe_in` ignored, `done` = 1.
  - Stays until `enable` low → IDLE.
- **`sync_clear` (RUN only):** `count` ← 0, `rate_act` ← `rate`, no strobe in this or the next cycle.
- **Rate updates:** a change on `rate` takes effect only at terminal count, IDLE→RUN, or `sync_clear`. It is never applied mid-period.
- **Arithmetic:** unsigned and modulo-free.
  - `rate` = 0 → every `strobe_in` produces `strobe_out`, delayed one clock.
  - `rate` = 2^WIDTH−1 → period of 2^WIDTH input strobes; no overflow, because the count never exceeds `rate_act`.
- **Priority, highest first:**
  1. `reset_n`
  2. `enable` low
  3. `sync_clear`
  4. terminal count
  5. increment
- **Simultaneous events:**
  - `sync_clear` together with a terminal `strobe_in` → no `strobe_out`, count = 0.
  - `enable` dropping on a terminal cycle → no `strobe_out`.

## Timing

- `strobe_out` latency is 1 clock after the terminal `strobe_in` edge. Width is exactly 1 clock.
- `count` and `active` are registered and update on the same edge as the state.
- Continuous `strobe_in` with `rate` = N gives `strobe_out` every N+1 clocks.
- The first output in RUN comes N+1 qualified strobes after entry.
- `done` asserts on the same edge as the final `strobe_out`.
- Mid-operation asynchronous reset clears everything immediately. Release is synchronised externally.

## Configuration

- **`WCA_STROBE_TICKS_EN` defined:**
  - `ticks` port and register exist.
  - Increments (wrapping) on every emitted `strobe_out`.
  - Cleared by reset and on IDLE→RUN.
- **Undefined:** no `ticks` port and no register. All other behaviour is identical.

## Structure

- **Package `wca_strobe_pkg`:** state typedef (IDLE/RUN/DONE) and mode constants (`STROBE_PERIODIC` = 0, `STROBE_ONESHOT` = 1).
- **Sub-module `wca_strobe_counter`:** WIDTH-parametrised count/compare core.
  - Inputs: `clear`, `inc`, `limit`.
  - Output: `terminal`.
- **Top level:** owns the FSM, `rate_act`, `mode_q`, the output register and `ticks`.

## Test plan

- **Periodic, constant strobe:** WIDTH = 24, `rate` = 3, `strobe_in` high continuously, `enable` high → `strobe_out` every 4 clocks, first one 5 clocks after `enable` rises; `count` sequence 0,1,2,3,0.
- **Rate change mid-period:** `rate` = 9 running, change `rate` to 1 at count = 4 → current period still ends at count 9; following periods are 2 strobes long.
- **One-shot:** `oneshot` = 1, `rate` = 2, strobes every 3rd clock → exactly one `strobe_out` after the 3rd strobe; `done` = 1; further strobes give no output. Dropping `enable` → IDLE, `done` = 0.
- **Collisions:** `sync_clear` asserted with a terminal `strobe_in` → no `strobe_out`, count = 0; next period is `rate+1` strobes.
- **Boundaries:** `rate` = 0 → `strobe_out` mirrors `strobe_in` delayed 1 clock. `rate` = 2^WIDTH−1 with WIDTH = 8 → period of 256 strobes, no early wrap.
- **Reset and ticks:** assert `reset_n` low mid-period → all outputs 0 asynchronously. With `WCA_STROBE_TICKS_EN`, `ticks` = 5 after 5 outputs, then returns to 0 on re-enable.
